// File: rtl/router_ingress_ctrl.sv
// rtl/router_ingress_ctrl.sv - router ingress FSM: header decode, FIFO write steering, parity check, counters
module router_ingress_ctrl #(
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             pkt_valid,
   input  logic [7:0]       data_in,
   input  logic [2:0]       fifo_full,
   input  logic [2:0]       fifo_empty,
   input  logic [2:0]       soft_reset,
   output logic             busy,
   output logic [7:0]       data_out,
   output logic [2:0]       write_enb,
   output logic             lfd_state,
   output logic             parity_err,
   output logic             err_valid,
   output logic [CNT_W-1:0] pkt_count,
   output logic [CNT_W-1:0] err_count,
   output logic             dropped
);

   typedef enum logic [2:0] {
      DECODE_ADDRESS  = 3'd0,
      WAIT_TILL_EMPTY = 3'd1,
      LOAD_FIRST_DATA = 3'd2,
      LOAD_DATA       = 3'd3,
      LOAD_PARITY     = 3'd4,
      CHECK_PARITY    = 3'd5
   } state_e;

   state_e           state_q, state_d;
   logic [7:0]       hdr_q, hdr_d;
   logic [1:0]       addr_q, addr_d;
   logic [5:0]       len_q, len_d;
   logic [7:0]       par_q, par_d;
   logic [7:0]       rx_par_q, rx_par_d;
   logic             parity_err_q, parity_err_d;
   logic             err_valid_q, err_valid_d;
   logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;
   logic             dropped_q, dropped_d;

   logic [2:0]       sel;
   logic             full_s, empty_s, soft_s, hdr_empty;
   logic             soft_abort, accept;

   // Per-FIFO view of the latched destination, plus the empty flag of the incoming header's destination
   always_comb begin
      sel       = 3'b000;
      full_s    = 1'b0;
      empty_s   = 1'b0;
      soft_s    = 1'b0;
      hdr_empty = 1'b0;
      case (addr_q)
         2'd0: begin sel = 3'b001; full_s = fifo_full[0]; empty_s = fifo_empty[0]; soft_s = soft_reset[0]; end
         2'd1: begin sel = 3'b010; full_s = fifo_full[1]; empty_s = fifo_empty[1]; soft_s = soft_reset[1]; end
         2'd2: begin sel = 3'b100; full_s = fifo_full[2]; empty_s = fifo_empty[2]; soft_s = soft_reset[2]; end
         default: ;
      endcase
      case (data_in[1:0])
         2'd0:    hdr_empty = fifo_empty[0];
         2'd1:    hdr_empty = fifo_empty[1];
         2'd2:    hdr_empty = fifo_empty[2];
         default: hdr_empty = 1'b0;
      endcase
   end

   // A soft reset only matters once a packet has been bound to a FIFO
   assign soft_abort = soft_s && (state_q != DECODE_ADDRESS);
   assign accept     = pkt_valid && !busy;

   // State register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state_q <= DECODE_ADDRESS;
      else         state_q <= state_d;
   end

   // Next-state logic; a soft reset on the bound FIFO abandons the packet from any state
   always_comb begin
      state_d = state_q;
      case (state_q)
         DECODE_ADDRESS:
            if (pkt_valid && (data_in[1:0] != 2'd3))
               state_d = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
         WAIT_TILL_EMPTY:
            if (empty_s) state_d = LOAD_FIRST_DATA;
         LOAD_FIRST_DATA:
            state_d = (len_q == 6'd0) ? LOAD_PARITY : LOAD_DATA;
         LOAD_DATA:
            if (accept && (len_q == 6'd1)) state_d = LOAD_PARITY;
         LOAD_PARITY:
            if (accept) state_d = CHECK_PARITY;
         CHECK_PARITY:
            state_d = DECODE_ADDRESS;
         default:
            state_d = DECODE_ADDRESS;
      endcase
      if (soft_abort) state_d = DECODE_ADDRESS;
   end

   // Output logic: source backpressure and FIFO write steering, never writing into a full FIFO
   always_comb begin
      busy      = 1'b0;
      write_enb = 3'b000;
      lfd_state = 1'b0;
      data_out  = 8'h00;
      case (state_q)
         WAIT_TILL_EMPTY: busy = 1'b1;
         LOAD_FIRST_DATA: begin
            busy      = 1'b1;
            lfd_state = 1'b1;
            data_out  = hdr_q;
            if (!full_s && !soft_abort) write_enb = sel;
         end
         LOAD_DATA, LOAD_PARITY: begin
            busy     = full_s;
            data_out = data_in;
            if (pkt_valid && !full_s && !soft_abort) write_enb = sel;
         end
         CHECK_PARITY: busy = 1'b1;
         default: ;
      endcase
   end

   // Datapath next-state: header capture, running parity, length countdown, check result and counters
   always_comb begin
      hdr_d        = hdr_q;
      addr_d       = addr_q;
      len_d        = len_q;
      par_d        = par_q;
      rx_par_d     = rx_par_q;
      parity_err_d = parity_err_q;
      err_valid_d  = 1'b0;
      pkt_count_d  = pkt_count_q;
      err_count_d  = err_count_q;
      dropped_d    = 1'b0;
      if (!soft_abort) begin
         case (state_q)
            DECODE_ADDRESS:
               if (pkt_valid) begin
                  if (data_in[1:0] == 2'd3) begin
                     dropped_d = 1'b1;
                  end else begin
                     hdr_d  = data_in;
                     addr_d = data_in[1:0];
                     len_d  = data_in[7:2];
                  end
               end
            LOAD_FIRST_DATA: par_d = hdr_q;
            LOAD_DATA:
               if (accept) begin
                  par_d = par_q ^ data_in;
                  len_d = len_q - 6'd1;
               end
            LOAD_PARITY:
               if (accept) rx_par_d = data_in;
            CHECK_PARITY: begin
               parity_err_d = (rx_par_q != par_q);
               err_valid_d  = 1'b1;
               pkt_count_d  = pkt_count_q + CNT_W'(1);
               if (rx_par_q != par_q) err_count_d = err_count_q + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Datapath registers
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         hdr_q        <= 8'h00;
         addr_q       <= 2'd0;
         len_q        <= 6'd0;
         par_q        <= 8'h00;
         rx_par_q     <= 8'h00;
         parity_err_q <= 1'b0;
         err_valid_q  <= 1'b0;
         pkt_count_q  <= '0;
         err_count_q  <= '0;
         dropped_q    <= 1'b0;
      end else begin
         hdr_q        <= hdr_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         par_q        <= par_d;
         rx_par_q     <= rx_par_d;
         parity_err_q <= parity_err_d;
         err_valid_q  <= err_valid_d;
         pkt_count_q  <= pkt_count_d;
         err_count_q  <= err_count_d;
         dropped_q    <= dropped_d;
      end
   end

   assign parity_err = parity_err_q;
   assign err_valid  = err_valid_q;
   assign pkt_count  = pkt_count_q;
   assign err_count  = err_count_q;
   assign dropped    = dropped_q;

endmodule

// File: tb/tb_router_ingress_ctrl.sv
// tb/tb_router_ingress_ctrl.sv - self-checking bench for router_ingress_ctrl
module tb_router_ingress_ctrl;

   logic       clock = 1'b0;
   logic       resetn;
   logic       pkt_valid;
   logic [7:0] data_in;
   logic [2:0] fifo_full, fifo_empty, soft_reset;
   logic       busy;
   logic [7:0] data_out;
   logic [2:0] write_enb;
   logic       lfd_state, parity_err, err_valid, dropped;
   logic [7:0] pkt_count, err_count;

   int checks   = 0;
   int failures = 0;
   logic [7:0] pay [64];

   router_ingress_ctrl #(.CNT_W(8)) dut (
      .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
      .busy(busy), .data_out(data_out), .write_enb(write_enb), .lfd_state(lfd_state),
      .parity_err(parity_err), .err_valid(err_valid), .pkt_count(pkt_count),
      .err_count(err_count), .dropped(dropped)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       pv;
      logic [7:0] d;
      logic [2:0] full;
      logic [2:0] empty;
      logic [2:0] sr;
      logic       busy;
      logic [2:0] we;
      logic       lfd;
      logic [7:0] dout;
      logic       ev;
      logic       perr;
      logic       drop;
   } vec_t;

   vec_t tbl [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // drive one cycle's inputs at the falling edge, leave outputs settled before the rising edge
   task automatic apply(input logic pv, input logic [7:0] d, input logic [2:0] ff,
                        input logic [2:0] fe, input logic [2:0] sr);
      @(negedge clock);
      pkt_valid  = pv;
      data_in    = d;
      fifo_full  = ff;
      fifo_empty = fe;
      soft_reset = sr;
      #2;
   endtask

   task automatic do_reset();
      @(negedge clock);
      resetn = 1'b0; pkt_valid = 1'b0; data_in = 8'h00;
      fifo_full = 3'b000; fifo_empty = 3'b111; soft_reset = 3'b000;
      @(negedge clock);
      resetn = 1'b1;
   endtask

   task automatic send_packet(input logic [7:0] hdr, input logic bad, input int stall_len,
                              input logic [7:0] exp_pkt, input logic [7:0] exp_err, input string tag);
      logic [7:0] bytes [$];
      logic [7:0] wd [$];
      logic       wl [$];
      logic [7:0] par;
      logic [2:0] we_exp, ff;
      int idx, stall_cnt, guard, n;
      we_exp = 3'b001 << hdr[1:0];
      par = hdr;
      bytes.push_back(hdr);
      for (int i = 0; i < int'(hdr[7:2]); i++) begin
         bytes.push_back(pay[i]);
         par ^= pay[i];
      end
      bytes.push_back(bad ? (par ^ 8'h01) : par);
      n = bytes.size(); idx = 0; stall_cnt = 0; guard = 0;
      while (idx < n && guard < 400) begin
         ff = (idx == 6 && stall_cnt < stall_len) ? we_exp : 3'b000;
         apply(1'b1, bytes[idx], ff, 3'b111, 3'b000);
         if (ff != 3'b000) begin
            chk({tag, "_stall_busy"}, 32'(busy), 32'd1);
            chk({tag, "_stall_we"}, 32'(write_enb), 32'd0);
            stall_cnt++;
         end
         if (write_enb != 3'b000) begin
            chk({tag, "_we_sel"}, 32'(write_enb), 32'(we_exp));
            wd.push_back(data_out);
            wl.push_back(lfd_state);
         end
         if (!busy) idx++;
         guard++;
      end
      if (guard >= 400) chk({tag, "_timeout"}, 32'd1, 32'd0);
      chk({tag, "_nwrites"}, 32'(wd.size()), 32'(n));
      for (int i = 0; i < n && i < wd.size(); i++) begin
         chk($sformatf("%s_byte%0d", tag, i), 32'(wd[i]), 32'(bytes[i]));
         chk($sformatf("%s_lfd%0d", tag, i), 32'(wl[i]), (i == 0) ? 32'd1 : 32'd0);
      end
      apply(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
      chk({tag, "_chk_busy"}, 32'(busy), 32'd1);
      chk({tag, "_chk_we"}, 32'(write_enb), 32'd0);
      chk({tag, "_ev_early"}, 32'(err_valid), 32'd0);
      apply(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
      chk({tag, "_ev"}, 32'(err_valid), 32'd1);
      chk({tag, "_perr"}, 32'(parity_err), 32'(bad));
      chk({tag, "_pkt_count"}, 32'(pkt_count), 32'(exp_pkt));
      chk({tag, "_err_count"}, 32'(err_count), 32'(exp_err));
      apply(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
      chk({tag, "_ev_once"}, 32'(err_valid), 32'd0);
   endtask

   initial begin
      logic [7:0] src_q [$];
      logic [10:0] exp_wr [$];
      logic        exp_par [$];
      logic [10:0] e;
      logic [7:0]  hdr, b, par, mpkt, merr, p0, p1;
      logic [1:0]  a2;
      logic [5:0]  l6;
      logic [2:0]  ff;
      logic        bad, pv, f;
      int exp_drops, drop_seen, tail;

      // packet 08 to FIFO0 with a stall and an idle, zero-length bad packet to FIFO1, then an addr-3 drop
      tbl[0]  = '{1'b1, 8'h08, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 8'hA5, 3'b000, 3'b111, 3'b000, 1'b1, 3'b001, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 8'hA5, 3'b001, 3'b111, 3'b000, 1'b1, 3'b000, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 8'hA5, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 8'hA5, 3'b000, 3'b111, 3'b000, 1'b0, 3'b001, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 8'h3C, 3'b000, 3'b111, 3'b000, 1'b0, 3'b001, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 8'h91, 3'b000, 3'b111, 3'b000, 1'b0, 3'b001, 1'b0, 8'h91, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 8'h01, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 8'h01, 3'b000, 3'b111, 3'b000, 1'b1, 3'b010, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 8'h00, 3'b000, 3'b111, 3'b000, 1'b0, 3'b010, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
      tbl[14] = '{1'b1, 8'hFF, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
      tbl[15] = '{1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
      tbl[16] = '{1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};

      for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);

      resetn = 1'b0; pkt_valid = 1'b0; data_in = 8'h00;
      fifo_full = 3'b000; fifo_empty = 3'b111; soft_reset = 3'b000;
      @(negedge clock);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_we", 32'(write_enb), 32'd0);
      chk("rst_lfd", 32'(lfd_state), 32'd0);
      chk("rst_dout", 32'(data_out), 32'd0);
      chk("rst_perr", 32'(parity_err), 32'd0);
      chk("rst_ev", 32'(err_valid), 32'd0);
      chk("rst_pkt", 32'(pkt_count), 32'd0);
      chk("rst_err", 32'(err_count), 32'd0);
      chk("rst_drop", 32'(dropped), 32'd0);
      @(negedge clock);
      resetn = 1'b1;

      for (int i = 0; i < 17; i++) begin
         apply(tbl[i].pv, tbl[i].d, tbl[i].full, tbl[i].empty, tbl[i].sr);
         chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
         chk($sformatf("tbl%0d_we", i), 32'(write_enb), 32'(tbl[i].we));
         chk($sformatf("tbl%0d_lfd", i), 32'(lfd_state), 32'(tbl[i].lfd));
         chk($sformatf("tbl%0d_dout", i), 32'(data_out), 32'(tbl[i].dout));
         chk($sformatf("tbl%0d_ev", i), 32'(err_valid), 32'(tbl[i].ev));
         chk($sformatf("tbl%0d_perr", i), 32'(parity_err), 32'(tbl[i].perr));
         chk($sformatf("tbl%0d_drop", i), 32'(dropped), 32'(tbl[i].drop));
      end

      do_reset();
      send_packet(8'h39, 1'b0, 0, 8'd1, 8'd0, "normal");
      send_packet(8'h39, 1'b1, 0, 8'd2, 8'd1, "badpar");
      send_packet(8'h39, 1'b0, 3, 8'd3, 8'd1, "bp");

      // header to FIFO2 while it is not empty: held off until it drains
      apply(1'b1, 8'h0A, 3'b000, 3'b011, 3'b000);
      chk("wait_hdr_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, pay[0], 3'b000, 3'b011, 3'b000);
         chk($sformatf("wait%0d_busy", i), 32'(busy), 32'd1);
         chk($sformatf("wait%0d_we", i), 32'(write_enb), 32'd0);
      end
      apply(1'b1, pay[0], 3'b000, 3'b111, 3'b000);
      chk("wait_exit_we", 32'(write_enb), 32'd0);
      apply(1'b1, pay[0], 3'b000, 3'b111, 3'b000);
      chk("wait_hdr_we", 32'(write_enb), 32'b100);
      chk("wait_hdr_lfd", 32'(lfd_state), 32'd1);
      chk("wait_hdr_dout", 32'(data_out), 32'h0A);
      apply(1'b1, pay[0], 3'b000, 3'b111, 3'b000);
      chk("wait_p0", 32'(data_out), 32'(pay[0]));
      chk("wait_p0_we", 32'(write_enb), 32'b100);
      apply(1'b1, pay[1], 3'b000, 3'b111, 3'b000);
      chk("wait_p1_we", 32'(write_enb), 32'b100);
      apply(1'b1, 8'h0A ^ pay[0] ^ pay[1], 3'b000, 3'b111, 3'b000);
      chk("wait_par_we", 32'(write_enb), 32'b100);
      apply(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
      apply(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
      chk("wait_ev", 32'(err_valid), 32'd1);
      chk("wait_perr", 32'(parity_err), 32'd0);
      chk("wait_pkt", 32'(pkt_count), 32'd4);

      apply(1'b1, 8'h0B, 3'b000, 3'b111, 3'b000);
      chk("drop_busy", 32'(busy), 32'd0);
      chk("drop_we", 32'(write_enb), 32'd0);
      apply(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
      chk("drop_pulse", 32'(dropped), 32'd1);
      chk("drop_we2", 32'(write_enb), 32'd0);
      apply(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
      chk("drop_pulse_end", 32'(dropped), 32'd0);
      chk("drop_pkt", 32'(pkt_count), 32'd4);

      // soft reset of FIFO1 while payload byte 7 is presented
      apply(1'b1, 8'h29, 3'b000, 3'b111, 3'b000);
      apply(1'b1, pay[0], 3'b000, 3'b111, 3'b000);
      chk("sr_hdr_we", 32'(write_enb), 32'b010);
      for (int i = 0; i < 7; i++) apply(1'b1, pay[i], 3'b000, 3'b111, 3'b000);
      apply(1'b1, pay[7], 3'b000, 3'b111, 3'b010);
      chk("sr_we", 32'(write_enb), 32'd0);
      apply(1'b0, 8'h00, 3'b010, 3'b111, 3'b000);
      chk("sr_busy_after", 32'(busy), 32'd0);
      chk("sr_we_after", 32'(write_enb), 32'd0);
      chk("sr_pkt", 32'(pkt_count), 32'd4);
      chk("sr_err", 32'(err_count), 32'd1);
      send_packet(8'h15, 1'b0, 0, 8'd5, 8'd1, "after_sr");

      // asynchronous reset in the middle of a payload, while FIFO1 is full
      apply(1'b1, 8'h39, 3'b000, 3'b111, 3'b000);
      apply(1'b1, pay[0], 3'b000, 3'b111, 3'b000);
      apply(1'b1, pay[0], 3'b000, 3'b111, 3'b000);
      apply(1'b1, pay[1], 3'b000, 3'b111, 3'b000);
      @(negedge clock);
      pkt_valid = 1'b1; data_in = pay[2]; fifo_full = 3'b010;
      #1;
      chk("arst_pre_busy", 32'(busy), 32'd1);
      #1;
      resetn = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_we", 32'(write_enb), 32'd0);
      chk("arst_lfd", 32'(lfd_state), 32'd0);
      chk("arst_pkt", 32'(pkt_count), 32'd0);
      chk("arst_err", 32'(err_count), 32'd0);
      @(negedge clock);
      pkt_valid = 1'b0; fifo_full = 3'b000; resetn = 1'b1;

      // 256 zero-length bad-parity packets: both counters wrap to zero
      for (int k = 0; k < 256; k++) begin
         apply(1'b1, 8'h00, 3'b000, 3'b111, 3'b000);
         if (k == 255) begin
            chk("wrap_pkt255", 32'(pkt_count), 32'd255);
            chk("wrap_err255", 32'(err_count), 32'd255);
         end
         apply(1'b1, 8'h01, 3'b000, 3'b111, 3'b000);
         apply(1'b1, 8'h01, 3'b000, 3'b111, 3'b000);
         apply(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
      end
      apply(1'b0, 8'h00, 3'b000, 3'b111, 3'b000);
      chk("wrap_pkt0", 32'(pkt_count), 32'd0);
      chk("wrap_err0", 32'(err_count), 32'd0);
      chk("wrap_perr", 32'(parity_err), 32'd1);

      // randomized traffic against a transaction-level expectation
      do_reset();
      exp_drops = 0;
      for (int p = 0; p < 40; p++) begin
         a2 = 2'($urandom_range(0, 3));
         if (a2 == 2'd3) begin
            l6 = 6'($urandom_range(0, 63));
            src_q.push_back({l6, 2'b11});
            exp_drops++;
         end else begin
            l6  = 6'($urandom_range(0, 12));
            hdr = {l6, a2};
            par = hdr;
            src_q.push_back(hdr);
            exp_wr.push_back({a2, 1'b1, hdr});
            for (int i = 0; i < int'(l6); i++) begin
               b = 8'($urandom);
               par ^= b;
               src_q.push_back(b);
               exp_wr.push_back({a2, 1'b0, b});
            end
            bad = ($urandom_range(0, 3) == 0);
            if (bad) par = par ^ (8'h01 << $urandom_range(0, 7));
            src_q.push_back(par);
            exp_wr.push_back({a2, 1'b0, par});
            exp_par.push_back(bad);
         end
      end
      mpkt = 8'd0; merr = 8'd0; drop_seen = 0; tail = 0;
      for (int cyc = 0; cyc < 20000 && tail < 4; cyc++) begin
         @(negedge clock);
         ff = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
         if (lfd_state) ff = 3'b000;
         pv = (src_q.size() != 0) && ($urandom_range(0, 3) != 0);
         pkt_valid  = pv;
         data_in    = pv ? src_q[0] : 8'($urandom);
         fifo_full  = ff;
         fifo_empty = 3'($urandom_range(0, 7));
         soft_reset = 3'b000;
         #2;
         if (pv && !busy) void'(src_q.pop_front());
         if (write_enb != 3'b000) begin
            chk("rnd_not_full", 32'(write_enb & fifo_full), 32'd0);
            if (exp_wr.size() == 0) begin
               chk("rnd_unexpected_write", 32'(write_enb), 32'd0);
            end else begin
               e = exp_wr.pop_front();
               chk("rnd_we", 32'(write_enb), 32'(3'b001 << e[10:9]));
               chk("rnd_lfd", 32'(lfd_state), 32'(e[8]));
               chk("rnd_data", 32'(data_out), 32'(e[7:0]));
            end
         end
         if (err_valid) begin
            if (exp_par.size() == 0) begin
               chk("rnd_unexpected_ev", 32'(err_valid), 32'd0);
            end else begin
               f = exp_par.pop_front();
               mpkt = mpkt + 8'd1;
               if (f) merr = merr + 8'd1;
               chk("rnd_perr", 32'(parity_err), 32'(f));
               chk("rnd_pkt", 32'(pkt_count), 32'(mpkt));
               chk("rnd_err", 32'(err_count), 32'(merr));
            end
         end
         if (dropped) drop_seen++;
         if (src_q.size() == 0 && exp_wr.size() == 0 && exp_par.size() == 0) tail++;
      end
      chk("rnd_timeout", 32'(tail), 32'd4);
      chk("rnd_drops", 32'(drop_seen), 32'(exp_drops));
      chk("rnd_left_writes", 32'(exp_wr.size()), 32'd0);
      chk("rnd_left_checks", 32'(exp_par.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
